// File: rtl/alu_32.sv
// alu_32 -- 32-bit integer ALU with a registered result and a sticky
// signed-overflow flag.
// Y, Z and Ovf are combinational from A, B and F. Yr and OvfSticky update on
// the rising edge of clk and are cleared by a synchronous, active-high reset.
// Optional feature: define ALU_SLTU_EN to make F=011 an unsigned set-less-than.
// Without it, F=011 gives Y=0 and Ovf=0.
module alu_32 (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  F,
  output logic [31:0] Y,
  output logic        Z,
  output logic        Ovf,
  output logic [31:0] Yr,
  output logic        OvfSticky
);

  logic [31:0] b_cond;
  logic [31:0] and_res;
  logic [31:0] or_res;
  logic [32:0] sum_full;
  logic [31:0] sum;
  logic        add_ovf;
  logic        slt_bit;
  logic        sltu_bit;
  logic [31:0] y_next;
  logic        ovf_next;
  logic [31:0] yr_reg;
  logic        ovf_sticky_reg;

  // F[2] inverts B, so AND/OR turn into AND-NOT/OR-NOT and ADD turns into SUB.
  assign b_cond = F[2] ? ~B : B;

  // Per-bit logic results.
  genvar gi;
  generate
    for (gi = 0; gi < 32; gi = gi + 1) begin : g_bitwise
      assign and_res[gi] = A[gi] & b_cond[gi];
      assign or_res[gi]  = A[gi] | b_cond[gi];
    end
  endgenerate

  // A single adder serves ADD, SUB and SLT; F[2] is the carry-in for SUB.
  assign sum_full = {1'b0, A} + {1'b0, b_cond} + {32'b0, F[2]};
  assign sum      = sum_full[31:0];

  // Signed overflow of the adder. The operands share a sign but the result's
  // sign differs. For SUB, b_cond = ~B, so this is A[31] != B[31].
  assign add_ovf = (A[31] == b_cond[31]) && (sum[31] != A[31]);

  // Signed less-than. When A-B overflows, the sign bit is wrong, so the overflow flag flips it.
  assign slt_bit = sum[31] ^ add_ovf;

`ifdef ALU_SLTU_EN
  logic [32:0] diff_full;

  // Separate subtract path for unsigned compare. F[2]=0 for this code, so the shared adder does an add.
  // A borrow (no carry out) means A < B unsigned.
  assign diff_full = {1'b0, A} + {1'b0, ~B} + 33'd1;
  assign sltu_bit  = ~diff_full[32];
`else
  assign sltu_bit  = 1'b0;
`endif

  // Select the result. Ovf is reported only for ADD and SUB.
  always_comb begin
    y_next   = 32'd0;
    ovf_next = 1'b0;
    case (F)
      3'b000, 3'b100: y_next = and_res;
      3'b001, 3'b101: y_next = or_res;
      3'b010, 3'b110: begin
        y_next   = sum;
        ovf_next = add_ovf;
      end
      3'b011:         y_next = {31'b0, sltu_bit};
      3'b111:         y_next = {31'b0, slt_bit};
      default:        y_next = 32'd0;
    endcase
  end

  assign Y   = y_next;
  assign Z   = ~|y_next;
  assign Ovf = ovf_next;

  // Register the result and accumulate overflow until reset.
  // Reset wins over a simultaneous overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      yr_reg         <= 32'd0;
      ovf_sticky_reg <= 1'b0;
    end else begin
      yr_reg         <= y_next;
      ovf_sticky_reg <= ovf_sticky_reg | ovf_next;
    end
  end

  assign Yr        = yr_reg;
  assign OvfSticky = ovf_sticky_reg;

endmodule

// File: tb/tb_alu_32.sv
// tb_alu_32 -- directed vectors plus random operations for alu_32. The
// checks use an arithmetic reference model of the ALU rules.
module tb_alu_32;

  logic        clk;
  logic        reset;
  logic [31:0] A;
  logic [31:0] B;
  logic [2:0]  F;
  logic [31:0] Y;
  logic        Z;
  logic        Ovf;
  logic [31:0] Yr;
  logic        OvfSticky;

  int tests_run = 0;
  int tests_failed = 0;

  // Model of the registered outputs.
  logic [31:0] m_yr;
  logic        m_sticky;

  alu_32 dut (
    .clk       (clk),
    .reset     (reset),
    .A         (A),
    .B         (B),
    .F         (F),
    .Y         (Y),
    .Z         (Z),
    .Ovf       (Ovf),
    .Yr        (Yr),
    .OvfSticky (OvfSticky)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

`ifdef ALU_SLTU_EN
  localparam logic [31:0] F3_Y12 = 32'd1;
`else
  localparam logic [31:0] F3_Y12 = 32'd0;
`endif

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  f;
    logic [31:0] y;
  } vec_t;

  localparam int NVEC = 27;
  vec_t vecs [0:NVEC-1] = '{
    '{32'h00000000, 32'h00000000, 3'd2, 32'h00000000},
    '{32'h00000000, 32'hFFFFFFFF, 3'd2, 32'hFFFFFFFF},
    '{32'h00000001, 32'hFFFFFFFF, 3'd2, 32'h00000000},
    '{32'h000000FF, 32'h00000001, 3'd2, 32'h00000100},
    '{32'h7FFFFFFF, 32'h00000001, 3'd2, 32'h80000000},
    '{32'h00000001, 32'h00000001, 3'd2, 32'h00000002},
    '{32'h00000000, 32'h00000000, 3'd6, 32'h00000000},
    '{32'h00000000, 32'hFFFFFFFF, 3'd6, 32'h00000001},
    '{32'h00000001, 32'h00000001, 3'd6, 32'h00000000},
    '{32'h00000100, 32'h00000001, 3'd6, 32'h000000FF},
    '{32'h80000000, 32'h00000001, 3'd6, 32'h7FFFFFFF},
    '{32'h00000000, 32'h00000000, 3'd7, 32'h00000000},
    '{32'h00000000, 32'h00000001, 3'd7, 32'h00000001},
    '{32'h00000000, 32'hFFFFFFFF, 3'd7, 32'h00000000},
    '{32'h00000001, 32'h00000000, 3'd7, 32'h00000000},
    '{32'hFFFFFFFF, 32'h00000000, 3'd7, 32'h00000001},
    '{32'h80000000, 32'h7FFFFFFF, 3'd7, 32'h00000001},
    '{32'hFFFFFFFF, 32'hFFFFFFFF, 3'd4, 32'h00000000},
    '{32'hFFFFFFFF, 32'h12345678, 3'd0, 32'h12345678},
    '{32'h12345678, 32'h87654321, 3'd0, 32'h02244220},
    '{32'h00000000, 32'hFFFFFFFF, 3'd4, 32'h00000000},
    '{32'hFFFFFFFF, 32'hFFFFFFFF, 3'd5, 32'hFFFFFFFF},
    '{32'h12345678, 32'h87654321, 3'd1, 32'h97755779},
    '{32'h00000000, 32'hFFFFFFFF, 3'd5, 32'h00000000},
    '{32'h00000000, 32'h00000000, 3'd1, 32'h00000000},
    '{32'h00000001, 32'h00000002, 3'd3, F3_Y12},
    '{32'hFFFFFFFF, 32'h00000000, 3'd3, 32'h00000000}
  };

  // Reference model. It uses plain signed/unsigned arithmetic on wide integers.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                input logic [2:0] f,
                                output logic [31:0] y, output logic ovf);
    longint sa;
    longint sb;
    longint r;
    sa  = $signed(a);
    sb  = $signed(b);
    r   = 0;
    y   = 32'd0;
    ovf = 1'b0;
    case (f)
      3'd0: y = a & b;
      3'd1: y = a | b;
      3'd2: begin
        r   = sa + sb;
        y   = r[31:0];
        ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      end
      3'd3: begin
`ifdef ALU_SLTU_EN
        y = (a < b) ? 32'd1 : 32'd0;
`else
        y = 32'd0;
`endif
      end
      3'd4: y = a & ~b;
      3'd5: y = a | ~b;
      3'd6: begin
        r   = sa - sb;
        y   = r[31:0];
        ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      end
      default: y = (sa < sb) ? 32'd1 : 32'd0;
    endcase
  endfunction

  // Run one transaction. Check the combinational outputs, then the registered ones after the next edge.
  // When chk_tbl is set, also check Y against the directed table value.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] f, input logic rst,
                       input logic chk_tbl, input logic [31:0] tbl_y);
    logic [31:0] ey;
    logic        eo;
    @(negedge clk);
    A = a;
    B = b;
    F = f;
    reset = rst;
    model(a, b, f, ey, eo);
    #1;
    tests_run++;
    assert (Y === ey) else begin
      tests_failed++;
      $error("FAIL Y f=%0d a=%h b=%h got %h want %h", f, a, b, Y, ey);
    end
    tests_run++;
    assert (Z === (ey == 32'd0)) else begin
      tests_failed++;
      $error("FAIL Z f=%0d a=%h b=%h got %b want %b", f, a, b, Z, (ey == 32'd0));
    end
    tests_run++;
    assert (Ovf === eo) else begin
      tests_failed++;
      $error("FAIL Ovf f=%0d a=%h b=%h got %b want %b", f, a, b, Ovf, eo);
    end
    if (chk_tbl) begin
      tests_run++;
      assert (Y === tbl_y) else begin
        tests_failed++;
        $error("FAIL Ytbl f=%0d a=%h b=%h got %h want %h", f, a, b, Y, tbl_y);
      end
    end
    if (rst) begin
      m_yr     = 32'd0;
      m_sticky = 1'b0;
    end else begin
      m_yr     = ey;
      m_sticky = m_sticky | eo;
    end
    @(posedge clk);
    #1;
    tests_run++;
    assert (Yr === m_yr) else begin
      tests_failed++;
      $error("FAIL Yr f=%0d a=%h b=%h got %h want %h", f, a, b, Yr, m_yr);
    end
    tests_run++;
    assert (OvfSticky === m_sticky) else begin
      tests_failed++;
      $error("FAIL OvfSticky f=%0d a=%h b=%h got %b want %b", f, a, b, OvfSticky, m_sticky);
    end
    $display("[TB] rst=%0d f=%0d a=%h b=%h y=%h z=%b ovf=%b yr=%h sticky=%b",
             rst, f, a, b, Y, Z, Ovf, Yr, OvfSticky);
  endtask

  initial begin
    A        = 32'd0;
    B        = 32'd0;
    F        = 3'd0;
    reset    = 1'b1;
    m_yr     = 32'd0;
    m_sticky = 1'b0;

    // Hold reset for one edge while the inputs overflow. Reset must win.
    do_op(32'h7FFFFFFF, 32'h00000001, 3'd2, 1'b1, 1'b1, 32'h80000000);

    // Directed vectors. The overflow entries set the sticky flag, and the following ones keep it set.
    for (int i = 0; i < NVEC; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].f, 1'b0, 1'b1, vecs[i].y);
    end

    // Reset while Ovf=1 clears the sticky flag.
    do_op(32'h80000000, 32'h00000001, 3'd6, 1'b1, 1'b0, 32'd0);
    do_op(32'h00000003, 32'h00000004, 3'd2, 1'b0, 1'b0, 32'd0);

    // Random operations, with a reset now and then.
    for (int i = 0; i < 300; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      logic [2:0]  rf;
      logic        rr;
      ra = $urandom;
      rb = $urandom;
      rf = 3'($urandom_range(0, 7));
      rr = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 7) == 0) rb = ra;
      do_op(ra, rb, rf, rr, 1'b0, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
